mc_ctrl_hs: RTL and testbench
=============================

// Module: mc_ctrl_hs
// PURPOSE
//  Multicycle MIPS control unit: main FSM plus ALU decode. Drives datapath muxes and enables.
//  Supersedes the fixed 9-state controller: adds addi, j, bne, a memory ready handshake,
//  a memory wait timeout, fault trapping and a per-instruction retire pulse.
//  Sits between the IR (opcode/funct), ALU Zero flag and the unified instruction/data memory.
// PARAMETERS
//  ALUCTL_W     4   ALUControl width; >=4; codes zero-extended above bit 3
//  MEM_TIMEOUT  16  max consecutive mem_ready=0 cycles in a memory state; 0 = no timeout
//  TRAP_FAULT   1   1: FAULT is terminal until reset; 0: one FAULT cycle, then FETCH
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   synchronous, active-high
//  Opcode       in   6   IR[31:26]
//  Funct        in   6   IR[5:0]
//  Zero         in   1   ALU zero flag
//  mem_ready    in   1   memory done this cycle (read data valid / write accepted)
//  mem_req      out  1   memory access request
//  IorD         out  1   0 = PC address, 1 = ALUOut address
//  MemWrite     out  1   write strobe, held with mem_req until mem_ready
//  IRWrite      out  1   latch instruction
//  PCEn         out  1   PC load enable
//  PCSrc        out  2   00 ALUResult, 01 ALUOut, 10 jump target {PC[31:28],IR[25:0],2'b00}
//  ALUSrcA      out  1   0 = PC, 1 = A reg
//  ALUSrcB      out  2   00 B, 01 const 4, 10 SignImm, 11 SignImm<<2
//  ALUControl   out  ALUCTL_W  add 0010 sub 0110 and 0000 or 0001 slt 0111 sllv 0011
//                            srlv 0101 srav 1000 sll 1011 srl 1101 sra 1100
//  shamt_c      out  1   1 for sll/srl/sra (shift by shamt field), only in RTYPE_EX
//  RegWrite     out  1   register file write enable
//  RegDst       out  1   0 = rt, 1 = rd
//  MemToReg     out  1   0 = ALUOut, 1 = data reg
//  retire       out  1   1-cycle pulse on the final cycle of each instruction
//  fault_cause  out  2   00 none, 01 illegal opcode, 10 mem timeout, 11 illegal R funct
// BEHAVIOUR
//  - Registered: state, wait counter, fault_cause. All other outputs decode from state/inputs.
//  - reset=1: next state FETCH, counter 0, fault_cause 00. During the reset cycle all outputs 0,
//    ALUControl = add. Reset mid-instruction abandons it, including a pending MemWrite.
//  - Unlisted outputs are 0 and ALUControl = add in each state below.
//  - FETCH: mem_req, IorD=0, SrcA=0, SrcB=01, add, PCSrc=00. mem_ready=1: IRWrite=1, PCEn=1,
//    ->DECODE; else hold, no IR/PC write.
//  - DECODE: SrcA=0, SrcB=11, add (branch target to ALUOut). lw/sw(100011/101011)->MEMADR,
//    R(000000) with legal funct->RTYPE_EX, R illegal funct->FAULT(11), beq/bne(000100/000101)
//    ->BRANCH, addi(001000)->ADDI_EX, j(000010)->JUMP, other->FAULT(01).
//  - MEMADR: SrcA=1, SrcB=10, add. ->MEMRD (lw) or MEMWR (sw).
//  - MEMRD: mem_req, IorD=1; mem_ready ->MEMWB else hold.
//    MEMWB: RegWrite, RegDst=0, MemToReg=1, retire ->FETCH.
//  - MEMWR: mem_req, IorD=1, MemWrite; mem_ready: retire ->FETCH, else hold.
//  - RTYPE_EX: SrcA=1, SrcB=00, ALUControl/shamt_c from funct ->ALU_WB.
//    ALU_WB: RegWrite, RegDst=1, MemToReg=0, retire ->FETCH.
//  - BRANCH: SrcA=1, SrcB=00, sub, PCSrc=01. PCEn = Zero (beq) or ~Zero (bne). retire ->FETCH.
//  - ADDI_EX: SrcA=1, SrcB=10, add ->ADDI_WB: RegWrite, RegDst=0, MemToReg=0, retire ->FETCH.
//  - JUMP: PCSrc=10, PCEn=1, retire ->FETCH.
//  - Wait counter: +1 each cycle in FETCH/MEMRD/MEMWR with mem_ready=0, cleared on mem_ready or
//    on leaving those states; saturates. When it equals MEM_TIMEOUT (!=0) and mem_ready=0 ->
//    FAULT(10). mem_ready on that same cycle wins: normal advance, no fault.
//  - FAULT: all strobes 0, mem_req 0. fault_cause set on entry, held while in FAULT.
//    TRAP_FAULT=1: stay until reset. TRAP_FAULT=0: one cycle ->FETCH, fault_cause cleared
//    on FETCH entry.
//  - Latencies (mem_ready immediate): lw 5, sw 4, R 4, addi 4, beq/bne 3, j 3 cycles.
// STRUCTURE
//  - Package mc_pkg: state enum, opcode/funct constants, ALUControl codes, ALUSrcB/PCSrc
//    encodings, fault codes.
//  - Sub-module mc_alu_decode: (ALUOp, Funct) -> ALUControl, shamt_c, funct_valid.
//    Combinational. DECODE uses funct_valid.
//  - Top: state register, next-state logic, wait counter, output decode.
// TESTING
//  - lw, mem_ready always 1: states F,D,MA,MR,MWB; retire on cycle 5; MemToReg=1 at MEMWB.
//  - sw, mem_ready low 3 cycles in MEMWR: MemWrite/mem_req held 4 cycles, one retire.
//    Counter peaks at 3, no fault.
//  - bne Zero=0: PCEn=1, PCSrc=01. beq Zero=0: PCEn=0. j: PCSrc=10, PCEn=1.
//  - MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH: FAULT after 4 wait cycles, fault_cause=10.
//    mem_ready rising on the 4th wait cycle: no fault.
//  - Opcode 111111: FAULT, fault_cause=01, held (TRAP_FAULT=1). Funct 111111: fault_cause=11.
//  - reset during MEMWR wait: next cycle FETCH, MemWrite=0, fault_cause=00, counter=0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_RTYPE_EX,
    S_ALU_WB,
    S_BRANCH,
    S_ADDI_EX,
    S_ADDI_WB,
    S_JUMP,
    S_FAULT
  } state_e;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_SRLV = 6'b000110;
  localparam logic [5:0] F_SRAV = 6'b000111;
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;

  // ALUControl codes (4-bit core, zero-extended at the top)
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLLV = 4'b0011;
  localparam logic [3:0] ALU_SRLV = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SRAV = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1011;
  localparam logic [3:0] ALU_SRA  = 4'b1100;
  localparam logic [3:0] ALU_SRL  = 4'b1101;

  // What the FSM asks of the ALU decoder
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  typedef enum logic [1:0] {
    SRCB_B      = 2'b00,
    SRCB_FOUR   = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_IMM_SH = 2'b11
  } srcb_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pcsrc_e;

  typedef enum logic [1:0] {
    FC_NONE          = 2'b00,
    FC_ILLEGAL_OP    = 2'b01,
    FC_TIMEOUT       = 2'b10,
    FC_ILLEGAL_FUNCT = 2'b11
  } fault_e;

endpackage

// File: rtl/mc_alu_decode.sv
// ALU decoder: maps the FSM's ALU request and the R-type funct field to an
// ALUControl code, the shift-by-shamt select, and a legal-funct flag.
module mc_alu_decode
  import mc_pkg::*;
(
  input  aluop_e      i_alu_op,
  input  logic [5:0]  i_funct,
  output logic [3:0]  o_alu_ctl,
  output logic        o_shamt_c,
  output logic        o_funct_valid
);

  logic [3:0] w_fn_ctl;
  logic       w_fn_shamt;

  // Funct lookup, then select by what the FSM is asking for.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    w_fn_ctl      = ALU_ADD;
    w_fn_shamt    = 1'b0;
    o_funct_valid = 1'b1;
    case (i_funct)
      F_ADD:   w_fn_ctl = ALU_ADD;
      F_SUB:   w_fn_ctl = ALU_SUB;
      F_AND:   w_fn_ctl = ALU_AND;
      F_OR:    w_fn_ctl = ALU_OR;
      F_SLT:   w_fn_ctl = ALU_SLT;
      F_SLLV:  w_fn_ctl = ALU_SLLV;
      F_SRLV:  w_fn_ctl = ALU_SRLV;
      F_SRAV:  w_fn_ctl = ALU_SRAV;
      F_SLL:   begin w_fn_ctl = ALU_SLL; w_fn_shamt = 1'b1; end
      F_SRL:   begin w_fn_ctl = ALU_SRL; w_fn_shamt = 1'b1; end
      F_SRA:   begin w_fn_ctl = ALU_SRA; w_fn_shamt = 1'b1; end
      default: o_funct_valid = 1'b0;
    endcase

    o_alu_ctl = ALU_ADD;
    o_shamt_c = 1'b0;
    case (i_alu_op)
      ALUOP_SUB:   o_alu_ctl = ALU_SUB;
      ALUOP_FUNCT: begin o_alu_ctl = w_fn_ctl; o_shamt_c = w_fn_shamt; end
      default:     o_alu_ctl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_hs.sv
// Multicycle MIPS control unit with memory ready handshake, memory wait
// timeout, fault trapping and a per-instruction retire pulse.
module mc_ctrl_hs
  import mc_pkg::*;
#(
  parameter int ALUCTL_W    = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int TRAP_FAULT  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          Opcode,
  input  logic [5:0]          Funct,
  input  logic                Zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                IorD,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                PCEn,
  output logic [1:0]          PCSrc,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [ALUCTL_W-1:0] ALUControl,
  output logic                shamt_c,
  output logic                RegWrite,
  output logic                RegDst,
  output logic                MemToReg,
  output logic                retire,
  output logic [1:0]          fault_cause
);

  // Counter wide enough to reach MEM_TIMEOUT; with no timeout it simply saturates.
  localparam int                CNT_W     = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(MEM_TIMEOUT);

  state_e           r_state;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [1:0]       r_fault_cause;

  logic             w_wait_state;
  logic             w_timeout;
  aluop_e           w_alu_op;
  logic [3:0]       w_alu_ctl;
  logic             w_shamt_c;
  logic             w_funct_valid;

  assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  // mem_ready on the limit cycle wins over the timeout.
  assign w_timeout    = (MEM_TIMEOUT != 0) && w_wait_state && !mem_ready &&
                        (r_wait_cnt == CNT_LIMIT);

  mc_alu_decode u_alu_decode (
    .i_alu_op      (w_alu_op),
    .i_funct       (Funct),
    .o_alu_ctl     (w_alu_ctl),
    .o_shamt_c     (w_shamt_c),
    .o_funct_valid (w_funct_valid)
  );

  // State register, wait counter and fault cause: the whole sequencing of one instruction.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_state       <= S_FETCH;
      r_wait_cnt    <= '0;
      r_fault_cause <= FC_NONE;
    end else begin
      if (w_wait_state && !mem_ready && !w_timeout) begin
        if (r_wait_cnt != '1) r_wait_cnt <= r_wait_cnt + 1'b1;
      end else begin
        r_wait_cnt <= '0;
      end

      case (r_state)
        S_FETCH: begin
          if (mem_ready) r_state <= S_DECODE;
          else if (w_timeout) begin
            r_state       <= S_FAULT;
            r_fault_cause <= FC_TIMEOUT;
          end
        end
        S_DECODE: begin
          case (Opcode)
            OP_LW, OP_SW:   r_state <= S_MEMADR;
            OP_BEQ, OP_BNE: r_state <= S_BRANCH;
            OP_ADDI:        r_state <= S_ADDI_EX;
            OP_J:           r_state <= S_JUMP;
            OP_RTYPE: begin
              if (w_funct_valid) r_state <= S_RTYPE_EX;
              else begin
                r_state       <= S_FAULT;
                r_fault_cause <= FC_ILLEGAL_FUNCT;
              end
            end
            default: begin
              r_state       <= S_FAULT;
              r_fault_cause <= FC_ILLEGAL_OP;
            end
          endcase
        end
        S_MEMADR:   r_state <= (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD: begin
          if (mem_ready) r_state <= S_MEMWB;
          else if (w_timeout) begin
            r_state       <= S_FAULT;
            r_fault_cause <= FC_TIMEOUT;
          end
        end
        S_MEMWR: begin
          if (mem_ready) r_state <= S_FETCH;
          else if (w_timeout) begin
            r_state       <= S_FAULT;
            r_fault_cause <= FC_TIMEOUT;
          end
        end
        S_RTYPE_EX: r_state <= S_ALU_WB;
        S_ADDI_EX:  r_state <= S_ADDI_WB;
        S_MEMWB, S_ALU_WB, S_BRANCH, S_ADDI_WB, S_JUMP: r_state <= S_FETCH;
        S_FAULT: begin
          if (TRAP_FAULT == 0) begin
            r_state       <= S_FETCH;
            r_fault_cause <= FC_NONE;
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Datapath controls decoded from the current state (and Zero / mem_ready where they gate a strobe).
  always_comb begin
    mem_req  = 1'b0;
    IorD     = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    PCEn     = 1'b0;
    PCSrc    = PCSRC_ALU;
    ALUSrcA  = 1'b0;
    ALUSrcB  = SRCB_B;
    RegWrite = 1'b0;
    RegDst   = 1'b0;
    MemToReg = 1'b0;
    retire   = 1'b0;
    w_alu_op = ALUOP_ADD;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          mem_req = 1'b1;
          ALUSrcB = SRCB_FOUR;
          IRWrite = mem_ready;
          PCEn    = mem_ready;
        end
        S_DECODE:   ALUSrcB = SRCB_IMM_SH;
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          RegWrite = 1'b1;
          MemToReg = 1'b1;
          retire   = 1'b1;
        end
        S_MEMWR: begin
          mem_req  = 1'b1;
          IorD     = 1'b1;
          MemWrite = 1'b1;
          retire   = mem_ready;
        end
        S_RTYPE_EX: begin
          ALUSrcA  = 1'b1;
          w_alu_op = ALUOP_FUNCT;
        end
        S_ALU_WB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
          retire   = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA  = 1'b1;
          w_alu_op = ALUOP_SUB;
          PCSrc    = PCSRC_ALUOUT;
          PCEn     = (Opcode == OP_BNE) ? ~Zero : Zero;
          retire   = 1'b1;
        end
        S_ADDI_EX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
        end
        S_ADDI_WB: begin
          RegWrite = 1'b1;
          retire   = 1'b1;
        end
        S_JUMP: begin
          PCSrc  = PCSRC_JUMP;
          PCEn   = 1'b1;
          retire = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Reset forces every output quiet in the cycle it is asserted.
  assign ALUControl  = ALUCTL_W'(w_alu_ctl);
  assign shamt_c     = w_shamt_c;
  assign fault_cause = reset ? FC_NONE : r_fault_cause;

endmodule

// File: tb/tb_mc_ctrl_hs.sv
// Self-checking bench for mc_ctrl_hs: directed vector table plus randomized
// instructions checked against an instruction-level expected-cycle model.
`timescale 1ns/1ps
module tb_mc_ctrl_hs;

  localparam int T = 4;  // MEM_TIMEOUT used for the DUT

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100,
                         BNE = 6'b000101, ADDI = 6'b001000, J = 6'b000010;

  localparam int NF = 11;
  localparam logic [5:0] FN_TAB  [NF] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                                          6'b000100, 6'b000110, 6'b000111, 6'b000000, 6'b000010,
                                          6'b000011};
  localparam logic [3:0] CTL_TAB [NF] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111,
                                          4'b0011, 4'b0101, 4'b1000, 4'b1011, 4'b1101, 4'b1100};
  localparam logic       SH_TAB  [NF] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                          1'b1, 1'b1, 1'b1};

  typedef struct packed {
    logic       mem_req, IorD, MemWrite, IRWrite, PCEn;
    logic [1:0] PCSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [3:0] ALUControl;
    logic       shamt_c, RegWrite, RegDst, MemToReg, retire;
    logic [1:0] fault_cause;
  } outs_t;

  typedef struct {
    logic       rst;
    logic [5:0] op, fn;
    logic       z, rdy;
    outs_t      e;
    string      nm;
  } vec_t;

  typedef struct {
    logic  rdy;
    outs_t e;
    string nm;
  } step_t;

  logic       clk = 1'b0;
  logic       reset, Zero, mem_ready;
  logic [5:0] Opcode, Funct;
  logic       mem_req, IorD, MemWrite, IRWrite, PCEn, ALUSrcA, shamt_c;
  logic       RegWrite, RegDst, MemToReg, retire;
  logic [1:0] PCSrc, ALUSrcB, fault_cause;
  logic [3:0] ALUControl;

  outs_t got;
  assign got = {mem_req, IorD, MemWrite, IRWrite, PCEn, PCSrc, ALUSrcA, ALUSrcB, ALUControl,
                shamt_c, RegWrite, RegDst, MemToReg, retire, fault_cause};

  int total = 0;
  int bad   = 0;
  vec_t  tbl[$];
  step_t q[$];

  always #5 clk = ~clk;

  mc_ctrl_hs #(.ALUCTL_W(4), .MEM_TIMEOUT(T), .TRAP_FAULT(1)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .IorD(IorD), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .PCEn(PCEn), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .shamt_c(shamt_c), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemToReg(MemToReg), .retire(retire), .fault_cause(fault_cause)
  );

  task automatic check(input string nm, input outs_t act, input outs_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h (fields mreq,iord,mw,irw,pcen,pcsrc,srca,srcb,alu,sh,rw,rd,m2r,ret,fc)",
               nm, act, exp);
    end
  endtask

  // ---- expected outputs per cycle kind, straight from the state table ----
  function automatic outs_t o_base();
    outs_t o = '0;
    o.ALUControl = 4'b0010;
    return o;
  endfunction
  function automatic outs_t f_fetch(logic r);
    outs_t o = o_base();
    o.mem_req = 1'b1; o.ALUSrcB = 2'b01; o.IRWrite = r; o.PCEn = r;
    return o;
  endfunction
  function automatic outs_t f_decode();
    outs_t o = o_base();
    o.ALUSrcB = 2'b11;
    return o;
  endfunction
  function automatic outs_t f_memadr();
    outs_t o = o_base();
    o.ALUSrcA = 1'b1; o.ALUSrcB = 2'b10;
    return o;
  endfunction
  function automatic outs_t f_memrd();
    outs_t o = o_base();
    o.mem_req = 1'b1; o.IorD = 1'b1;
    return o;
  endfunction
  function automatic outs_t f_memwb();
    outs_t o = o_base();
    o.RegWrite = 1'b1; o.MemToReg = 1'b1; o.retire = 1'b1;
    return o;
  endfunction
  function automatic outs_t f_memwr(logic r);
    outs_t o = o_base();
    o.mem_req = 1'b1; o.IorD = 1'b1; o.MemWrite = 1'b1; o.retire = r;
    return o;
  endfunction
  function automatic outs_t f_rex(logic [3:0] ctl, logic sh);
    outs_t o = o_base();
    o.ALUSrcA = 1'b1; o.ALUControl = ctl; o.shamt_c = sh;
    return o;
  endfunction
  function automatic outs_t f_alu_wb();
    outs_t o = o_base();
    o.RegWrite = 1'b1; o.RegDst = 1'b1; o.retire = 1'b1;
    return o;
  endfunction
  function automatic outs_t f_branch(logic take);
    outs_t o = o_base();
    o.ALUSrcA = 1'b1; o.ALUControl = 4'b0110; o.PCSrc = 2'b01; o.PCEn = take; o.retire = 1'b1;
    return o;
  endfunction
  function automatic outs_t f_addi_ex();
    outs_t o = o_base();
    o.ALUSrcA = 1'b1; o.ALUSrcB = 2'b10;
    return o;
  endfunction
  function automatic outs_t f_addi_wb();
    outs_t o = o_base();
    o.RegWrite = 1'b1; o.retire = 1'b1;
    return o;
  endfunction
  function automatic outs_t f_jump();
    outs_t o = o_base();
    o.PCSrc = 2'b10; o.PCEn = 1'b1; o.retire = 1'b1;
    return o;
  endfunction
  function automatic outs_t f_fault(logic [1:0] c);
    outs_t o = o_base();
    o.fault_cause = c;
    return o;
  endfunction

  // ---- helpers ----
  function automatic void add(logic rst, logic [5:0] op, logic [5:0] fn, logic z, logic rdy,
                              outs_t e, string nm);
    vec_t v;
    v.rst = rst; v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.e = e; v.nm = nm;
    tbl.push_back(v);
  endfunction

  function automatic int fn_index(logic [5:0] f);
    for (int i = 0; i < NF; i++) if (FN_TAB[i] == f) return i;
    return -1;
  endfunction

  function automatic bit op_legal(logic [5:0] op);
    return op inside {LW, SW, RT, BEQ, BNE, ADDI, J};
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push(logic rdy, outs_t e, string nm);
    step_t s;
    s.rdy = rdy; s.e = e; s.nm = nm;
    q.push_back(s);
  endfunction

  function automatic outs_t ph(int kind, logic r);
    if (kind == 0) return f_fetch(r);
    if (kind == 1) return f_memrd();
    return f_memwr(r);
  endfunction

  // A memory phase with w idle-ready cycles before mem_ready. It survives as
  // long as the ready arrives while the count of prior waits is <= T.
  function automatic bit wait_phase(int kind, int w, string nm);
    int n = (w > T) ? T + 1 : w;
    for (int i = 0; i < n; i++) push(1'b0, ph(kind, 1'b0), nm);
    if (w > T) begin
      push(rbit(), f_fault(2'b10), "rnd_timeout_fault");
      push(rbit(), f_fault(2'b10), "rnd_timeout_held");
      return 1'b1;
    end
    push(1'b1, ph(kind, 1'b1), nm);
    return 1'b0;
  endfunction

  // Instruction-level model: expected cycle list for one instruction. Returns 1 if it faults.
  function automatic bit model(logic [5:0] op, logic [5:0] fn, logic z, int wf, int wm);
    int idx;
    q.delete();
    if (wait_phase(0, wf, "rnd_fetch")) return 1'b1;
    push(rbit(), f_decode(), "rnd_decode");
    case (op)
      LW: begin
        push(rbit(), f_memadr(), "rnd_lw_memadr");
        if (wait_phase(1, wm, "rnd_memrd")) return 1'b1;
        push(rbit(), f_memwb(), "rnd_memwb");
      end
      SW: begin
        push(rbit(), f_memadr(), "rnd_sw_memadr");
        if (wait_phase(2, wm, "rnd_memwr")) return 1'b1;
      end
      RT: begin
        idx = fn_index(fn);
        if (idx < 0) begin
          push(rbit(), f_fault(2'b11), "rnd_funct_fault");
          push(rbit(), f_fault(2'b11), "rnd_funct_held");
          return 1'b1;
        end
        push(rbit(), f_rex(CTL_TAB[idx], SH_TAB[idx]), "rnd_rtype_ex");
        push(rbit(), f_alu_wb(), "rnd_alu_wb");
      end
      BEQ:  push(rbit(), f_branch(z), "rnd_beq");
      BNE:  push(rbit(), f_branch(!z), "rnd_bne");
      ADDI: begin
        push(rbit(), f_addi_ex(), "rnd_addi_ex");
        push(rbit(), f_addi_wb(), "rnd_addi_wb");
      end
      J:    push(rbit(), f_jump(), "rnd_jump");
      default: begin
        push(rbit(), f_fault(2'b01), "rnd_op_fault");
        push(rbit(), f_fault(2'b01), "rnd_op_held");
        return 1'b1;
      end
    endcase
    return 1'b0;
  endfunction

  function automatic int pick_wait();
    return ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 5));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [5:0] op, fn;
    logic       z, flt;
    int         k;

    reset = 1'b1; Opcode = '0; Funct = '0; Zero = 1'b0; mem_ready = 1'b0;

    // ---- directed vector table ----
    add(1, RT, 0, 0, 1, o_base(), "reset_outputs");
    add(0, LW, 0, 0, 1, f_fetch(1), "lw_fetch");
    add(0, LW, 0, 0, 1, f_decode(), "lw_decode");
    add(0, LW, 0, 0, 1, f_memadr(), "lw_memadr");
    add(0, LW, 0, 0, 1, f_memrd(), "lw_memrd");
    add(0, LW, 0, 0, 1, f_memwb(), "lw_memwb_retire");
    add(0, SW, 0, 0, 1, f_fetch(1), "sw_fetch");
    add(0, SW, 0, 0, 0, f_decode(), "sw_decode");
    add(0, SW, 0, 0, 0, f_memadr(), "sw_memadr");
    repeat (3) add(0, SW, 0, 0, 0, f_memwr(0), "sw_wait_held");
    add(0, SW, 0, 0, 1, f_memwr(1), "sw_accept_retire");
    add(0, BNE, 0, 0, 1, f_fetch(1), "bne_fetch");
    add(0, BNE, 0, 0, 1, f_decode(), "bne_decode");
    add(0, BNE, 0, 0, 1, f_branch(1), "bne_z0_taken");
    add(0, BEQ, 0, 0, 1, f_fetch(1), "beq_fetch");
    add(0, BEQ, 0, 0, 1, f_decode(), "beq_decode");
    add(0, BEQ, 0, 0, 1, f_branch(0), "beq_z0_not_taken");
    add(0, BEQ, 0, 1, 1, f_fetch(1), "beq_fetch");
    add(0, BEQ, 0, 1, 1, f_decode(), "beq_decode");
    add(0, BEQ, 0, 1, 1, f_branch(1), "beq_z1_taken");
    add(0, BNE, 0, 1, 1, f_fetch(1), "bne_fetch");
    add(0, BNE, 0, 1, 1, f_decode(), "bne_decode");
    add(0, BNE, 0, 1, 1, f_branch(0), "bne_z1_not_taken");
    add(0, J, 0, 0, 1, f_fetch(1), "j_fetch");
    add(0, J, 0, 0, 1, f_decode(), "j_decode");
    add(0, J, 0, 0, 1, f_jump(), "j_jump");
    add(0, ADDI, 0, 0, 1, f_fetch(1), "addi_fetch");
    add(0, ADDI, 0, 0, 1, f_decode(), "addi_decode");
    add(0, ADDI, 0, 0, 1, f_addi_ex(), "addi_ex");
    add(0, ADDI, 0, 0, 1, f_addi_wb(), "addi_wb");
    add(0, RT, 6'b100010, 0, 1, f_fetch(1), "sub_fetch");
    add(0, RT, 6'b100010, 0, 1, f_decode(), "sub_decode");
    add(0, RT, 6'b100010, 0, 1, f_rex(4'b0110, 0), "sub_ex");
    add(0, RT, 6'b100010, 0, 1, f_alu_wb(), "sub_wb");
    add(0, RT, 6'b000011, 0, 1, f_fetch(1), "sra_fetch");
    add(0, RT, 6'b000011, 0, 1, f_decode(), "sra_decode");
    add(0, RT, 6'b000011, 0, 1, f_rex(4'b1100, 1), "sra_ex_shamt");
    add(0, RT, 6'b000011, 0, 1, f_alu_wb(), "sra_wb");
    repeat (4) add(0, J, 0, 0, 0, f_fetch(0), "fetch_wait");
    add(0, J, 0, 0, 1, f_fetch(1), "fetch_ready_at_limit");
    add(0, J, 0, 0, 1, f_decode(), "limit_decode");
    add(0, J, 0, 0, 1, f_jump(), "limit_jump");
    add(0, 6'b111111, 0, 0, 1, f_fetch(1), "badop_fetch");
    add(0, 6'b111111, 0, 0, 1, f_decode(), "badop_decode");
    add(0, 6'b111111, 0, 0, 1, f_fault(2'b01), "badop_fault");
    repeat (2) add(0, 6'b111111, 0, 0, 1, f_fault(2'b01), "badop_trap_held");
    add(1, 6'b111111, 0, 0, 1, o_base(), "badop_reset");
    add(0, RT, 6'b111111, 0, 1, f_fetch(1), "badfn_fetch");
    add(0, RT, 6'b111111, 0, 1, f_decode(), "badfn_decode");
    add(0, RT, 6'b111111, 0, 1, f_fault(2'b11), "badfn_fault");
    add(0, RT, 6'b111111, 0, 0, f_fault(2'b11), "badfn_held");
    add(1, RT, 0, 0, 0, o_base(), "badfn_reset");
    repeat (5) add(0, J, 0, 0, 0, f_fetch(0), "fetch_stuck");
    repeat (2) add(0, J, 0, 0, 0, f_fault(2'b10), "fetch_timeout_fault");
    add(1, J, 0, 0, 0, o_base(), "timeout_reset");
    add(0, SW, 0, 0, 1, f_fetch(1), "swr_fetch");
    add(0, SW, 0, 0, 1, f_decode(), "swr_decode");
    add(0, SW, 0, 0, 1, f_memadr(), "swr_memadr");
    repeat (2) add(0, SW, 0, 0, 0, f_memwr(0), "swr_wait");
    add(1, SW, 0, 0, 0, o_base(), "reset_mid_memwr");
    repeat (4) add(0, J, 0, 0, 0, f_fetch(0), "post_reset_fetch_wait");
    add(0, J, 0, 0, 1, f_fetch(1), "post_reset_fetch_ready");
    add(0, J, 0, 0, 1, f_decode(), "post_reset_decode");
    add(0, J, 0, 0, 1, f_jump(), "post_reset_jump");

    foreach (tbl[i]) begin
      reset = tbl[i].rst; Opcode = tbl[i].op; Funct = tbl[i].fn;
      Zero = tbl[i].z; mem_ready = tbl[i].rdy;
      #2;
      check(tbl[i].nm, got, tbl[i].e);
      tick();
    end
    reset = 1'b0;

    // ---- randomized instructions against the model ----
    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(0, 8);
      fn = 6'($urandom);
      case (k)
        0: op = LW;
        1: op = SW;
        2, 3: begin
          op = RT;
          if ($urandom_range(0, 7) == 0) begin
            do fn = 6'($urandom); while (fn_index(fn) >= 0);
          end else begin
            fn = FN_TAB[$urandom_range(0, NF - 1)];
          end
        end
        4: op = BEQ;
        5: op = BNE;
        6: op = ADDI;
        7: op = J;
        default: do op = 6'($urandom); while (op_legal(op));
      endcase
      z   = rbit();
      flt = model(op, fn, z, pick_wait(), pick_wait());
      Opcode = op; Funct = fn; Zero = z; reset = 1'b0;
      foreach (q[i]) begin
        mem_ready = q[i].rdy;
        #2;
        check(q[i].nm, got, q[i].e);
        tick();
      end
      if (flt) begin
        reset = 1'b1; mem_ready = rbit();
        #2;
        check("rnd_reset", got, o_base());
        tick();
        reset = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
